rfx_ad7641_axi_regs: RTL and testbench

RFX_AD7641_AXI_REGS -- requirements
Module: rfx_ad7641_axi_regs

---
 rtl/rfx_ad7641_pkg.sv | 11 +
 rtl/rfx_ad7641_axi_regs_if.sv | 34 +++
 rtl/rfx_ad7641_axil_wstrb_merge.sv | 13 +
 rtl/rfx_ad7641_axi_regs.sv | 68 ++++++
 tb/tb_rfx_ad7641_axi_regs.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rfx_ad7641_pkg.sv
// rfx_ad7641_pkg: register indices, response codes and shared types for the AD7641 AXI-Lite register bank
package rfx_ad7641_pkg;
  localparam int NUM_REGS = 4;
  typedef logic [1:0] reg_idx_t;
  typedef logic [1:0] resp_t;
  localparam reg_idx_t REG_CTRL = 2'd0;
  localparam reg_idx_t REG_CFG = 2'd1;
  localparam reg_idx_t REG_DEC = 2'd2;
  localparam reg_idx_t REG_STAT = 2'd3;
  localparam resp_t RESP_OKAY = 2'b00;
endpackage

// File: rtl/rfx_ad7641_axi_regs_if.sv
// rfx_ad7641_axi_regs_if: AXI4-Lite bus bundle; master drives addresses/data/ready-for-response, slave drives readies/responses
interface rfx_ad7641_axi_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  import rfx_ad7641_pkg::*;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wvalid;
  logic wready;
  resp_t bresp;
  logic bvalid;
  logic bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [DATA_W-1:0] rdata;
  resp_t rresp;
  logic rvalid;
  logic rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rfx_ad7641_axil_wstrb_merge.sv
// rfx_ad7641_axil_wstrb_merge: byte-lane merge of wdata into cur under wstrb, result on merged
module rfx_ad7641_axil_wstrb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   cur,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  output logic [DW-1:0]   merged
);
  for (genvar i = 0; i < DW / 8; i++) begin : g_lane
    assign merged[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
  end
endmodule

// File: rtl/rfx_ad7641_axi_regs.sv
// rfx_ad7641_axi_regs: four-register AXI4-Lite slave feeding the AD7641 capture logic
// ports: s00_axi_aclk/s00_axi_areset clock and async reset, s00_axi slave bus, reg0..reg3 contents, reg_wr_pulse write strobes
module rfx_ad7641_axi_regs
  import rfx_ad7641_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  rfx_ad7641_axi_regs_if.slave          s00_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3,
  output logic [NUM_REGS-1:0]           reg_wr_pulse
);
  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic [C_S_AXI_DATA_WIDTH-1:0] merged, rdata;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic aw_w_rdy, bvalid, arready, rvalid, wr_hs, rd_hs, unused_ok;
  reg_idx_t widx, ridx;
  assign awaddr = s00_axi.awaddr;
  assign araddr = s00_axi.araddr;
  assign widx = awaddr[3:2];
  assign ridx = araddr[3:2];
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, awaddr, araddr};
  // awready/wready share one flop so the AW and W handshakes always land on the same edge
  assign wr_hs = aw_w_rdy & s00_axi.awvalid & s00_axi.wvalid;
  assign rd_hs = arready & s00_axi.arvalid;
  rfx_ad7641_axil_wstrb_merge #(.DW(C_S_AXI_DATA_WIDTH)) u_merge (
    .cur(regs[widx]),
    .wdata(s00_axi.wdata),
    .wstrb(s00_axi.wstrb),
    .merged(merged)
  );
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      regs <= '0;
      aw_w_rdy <= 1'b0;
      bvalid <= 1'b0;
      reg_wr_pulse <= '0;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      aw_w_rdy <= ~aw_w_rdy & s00_axi.awvalid & s00_axi.wvalid & ~bvalid;
      bvalid <= wr_hs | (bvalid & ~s00_axi.bready);
      reg_wr_pulse <= wr_hs ? NUM_REGS'(1) << widx : '0;
      if (wr_hs) regs[widx] <= merged;
      arready <= ~arready & s00_axi.arvalid & ~rvalid;
      rvalid <= rd_hs | (rvalid & ~s00_axi.rready);
      if (rd_hs) rdata <= regs[ridx];
    end
  end
  assign s00_axi.awready = aw_w_rdy;
  assign s00_axi.wready = aw_w_rdy;
  assign s00_axi.bvalid = bvalid;
  assign s00_axi.bresp = RESP_OKAY;
  assign s00_axi.arready = arready;
  assign s00_axi.rvalid = rvalid;
  assign s00_axi.rdata = rdata;
  assign s00_axi.rresp = RESP_OKAY;
  assign reg0 = regs[REG_CTRL];
  assign reg1 = regs[REG_CFG];
  assign reg2 = regs[REG_DEC];
  assign reg3 = regs[REG_STAT];
endmodule

// File: tb/tb_rfx_ad7641_axi_regs.sv
// tb_rfx_ad7641_axi_regs: directed self-checking bench for the AD7641 AXI-Lite register bank
module tb_rfx_ad7641_axi_regs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0] reg_wr_pulse;
  int n_pass = 0;
  int n_tot = 0;
  rfx_ad7641_axi_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();
  rfx_ad7641_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk(clk),
    .s00_axi_areset(rst),
    .s00_axi(bus),
    .reg0(reg0),
    .reg1(reg1),
    .reg2(reg2),
    .reg3(reg3),
    .reg_wr_pulse(reg_wr_pulse)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic wr_start(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.awaddr = addr;
    bus.wdata = data;
    bus.wstrb = strb;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
  endtask
  task automatic wait_aw(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.awready && n < 20);
    chk(tag, 32'(bus.awready), 32'd1);
  endtask
  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input bit hold_b, output logic [3:0] pulse);
    wr_start(addr, data, strb);
    wait_aw("aw_ready");
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    chk("bvalid_rise", 32'(bus.bvalid), 32'd1);
    chk("bresp", 32'(bus.bresp), 32'd0);
    pulse = reg_wr_pulse;
    if (!hold_b) begin
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
    end
  endtask
  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    int n = 0;
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    do begin
      tick();
      n++;
    end while (!bus.arready && n < 20);
    chk("ar_ready", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    chk("rvalid_rise", 32'(bus.rvalid), 32'd1);
    chk("rresp", 32'(bus.rresp), 32'd0);
    data = bus.rdata;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask
  initial begin
    logic [31:0] d;
    logic [3:0] p;
    logic [31:0] vals [3];
    vals[0] = 32'hABCD0001;
    vals[1] = 32'hDEAD0011;
    vals[2] = 32'hBEEF0011;
    bus.awaddr = '0;
    bus.awprot = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0;
    bus.arprot = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (2) tick();
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    chk("rst_pulse", 32'(reg_wr_pulse), 32'd0);
    rst = 1'b0;
    wr(4'h0, 32'h0101FFFF, 4'hF, 1'b0, p);
    chk("w0_pulse", 32'(p), 32'h1);
    chk("w0_pulse_end", 32'(reg_wr_pulse), 32'h0);
    chk("w0_reg0", reg0, 32'h0101FFFF);
    rd(4'h0, d);
    chk("r0_data", d, 32'h0101FFFF);
    for (int i = 0; i < 3; i++) begin
      wr(4'((i + 1) * 4), vals[i], 4'hF, 1'b0, p);
      chk("seq_pulse", 32'(p), 32'(4'(1) << (i + 1)));
      rd(4'((i + 1) * 4), d);
      chk("seq_rdata", d, vals[i]);
      chk("seq_reg", i == 0 ? reg1 : i == 1 ? reg2 : reg3, vals[i]);
    end
    wr(4'h8, 32'h12345678, 4'b0101, 1'b0, p);
    chk("strb_reg2", reg2, 32'hDE340078);
    chk("strb_pulse", 32'(p), 32'h4);
    bus.awaddr = 4'h0;
    bus.wdata = 32'h00000005;
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("aw_only_awready", 32'(bus.awready), 32'd0);
    end
    bus.wvalid = 1'b1;
    tick();
    chk("aw_late_awready", 32'(bus.awready), 32'd1);
    chk("aw_late_wready", 32'(bus.wready), 32'd1);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    chk("aw_late_awready_drop", 32'(bus.awready | bus.wready), 32'd0);
    chk("aw_late_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("aw_late_reg0", reg0, 32'h00000005);
    wr(4'h0, 32'h11111111, 4'hF, 1'b1, p);
    bus.araddr = 4'h4;
    bus.arvalid = 1'b1;
    tick();
    chk("hold_arready", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    chk("hold_rvalid", 32'(bus.rvalid), 32'd1);
    wr_start(4'h4, 32'h22222222, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_bvalid", 32'(bus.bvalid), 32'd1);
      chk("hold_rvalid", 32'(bus.rvalid), 32'd1);
      chk("hold_rdata", bus.rdata, 32'hABCD0001);
      chk("hold_no_accept", 32'(bus.awready), 32'd0);
    end
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    chk("hold_release", 32'({bus.bvalid, bus.rvalid, bus.awready}), 32'd0);
    wait_aw("hold_second_aw");
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    chk("hold_second_bvalid", 32'(bus.bvalid), 32'd1);
    chk("hold_second_pulse", 32'(reg_wr_pulse), 32'h2);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("hold_reg0", reg0, 32'h11111111);
    chk("hold_reg1", reg1, 32'h22222222);
    wr_start(4'h8, 32'h44444444, 4'hF);
    bus.araddr = 4'h8;
    bus.arvalid = 1'b1;
    tick();
    chk("rw_ready", 32'({bus.awready, bus.arready}), 32'h3);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    bus.arvalid = 1'b0;
    chk("rw_old_rdata", bus.rdata, 32'hDE340078);
    chk("rw_reg2", reg2, 32'h44444444);
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    rd(4'h8, d);
    chk("rw_new_rdata", d, 32'h44444444);
    wr(4'hC, 32'hBEEF0011, 4'hF, 1'b1, p);
    chk("prerst_reg3", reg3, 32'hBEEF0011);
    rst = 1'b1;
    #1;
    chk("async_bvalid", 32'(bus.bvalid), 32'd0);
    chk("async_reg3", reg3, 32'd0);
    chk("async_reg0", reg0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wr_start(4'h4, 32'h000000A5, 4'hF);
    tick();
    chk("post_rst_awready", 32'(bus.awready), 32'd1);
    chk("post_rst_no_bvalid", 32'(bus.bvalid), 32'd0);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    chk("post_rst_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("post_rst_reg1", reg1, 32'h000000A5);
    chk("post_rst_reg3", reg3, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
